// File: rtl/rx_pkg.sv
// ---------------------------------------------------------------------------
// rx_pkg
// Shared types and default constants for the UART receive buffer controller.
//   rx_entry_t  : one FIFO entry {dat, pErr, fErr}
//   to_state_e  : receive idle-timeout FSM states
//   RX_FIFO_DEPTH / RX_TIMEOUT_TICKS : default parameter values
// ---------------------------------------------------------------------------
package rx_pkg;

   localparam int RX_FIFO_DEPTH    = 4;
   // 4 character times of 10 bits at 8x oversampling
   localparam int RX_TIMEOUT_TICKS = 320;

   typedef struct packed {
      logic [7:0] dat;
      logic       pErr;
      logic       fErr;
   } rx_entry_t;

   typedef enum logic [1:0] {
      TO_IDLE    = 2'd0,
      TO_COUNT   = 2'd1,
      TO_EXPIRED = 2'd2
   } to_state_e;

endpackage

// File: rtl/rx_timeout_timer.sv
// ---------------------------------------------------------------------------
// rx_timeout_timer
// Idle-timeout FSM for the receive FIFO. While the FIFO holds data, counts
// baud ticks since the last write strobe or pop and flags a timeout once
// TIMEOUT_TICKS ticks pass with no activity.
// Ports:
//   clk, arst      : clock, asynchronous active-high reset
//   tick_i         : 8x baud tick
//   move_i         : receive core delivered a character (kept or dropped)
//   pop_i          : an entry is popped this cycle
//   empty_next_i   : FIFO will be empty after this edge
//   timeout_o      : 1 while in the EXPIRED state
// ---------------------------------------------------------------------------
module rx_timeout_timer
   import rx_pkg::*;
#(
   parameter int TIMEOUT_TICKS = RX_TIMEOUT_TICKS
) (
   input  logic clk,
   input  logic arst,
   input  logic tick_i,
   input  logic move_i,
   input  logic pop_i,
   input  logic empty_next_i,
   output logic timeout_o
);

   localparam int TW = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;
   localparam logic [TW-1:0] LAST_TICK = TW'(TIMEOUT_TICKS - 1);

   to_state_e     state_q, state_d;
   logic [TW-1:0] tick_cnt_q, tick_cnt_d;

   // Next-state logic; leaving IDLE and any exit to IDLE use the post-edge fill level
   always_comb begin
      state_d    = state_q;
      tick_cnt_d = tick_cnt_q;
      case (state_q)
         TO_IDLE: begin
            if (!empty_next_i) begin
               state_d    = TO_COUNT;
               tick_cnt_d = {TW{1'b0}};
            end else begin
               state_d    = TO_IDLE;
            end
         end
         TO_COUNT: begin
            if (empty_next_i) begin
               state_d    = TO_IDLE;
               tick_cnt_d = {TW{1'b0}};
            end else if (move_i || pop_i) begin
               tick_cnt_d = {TW{1'b0}};
            end else if (tick_i) begin
               if (tick_cnt_q == LAST_TICK) begin
                  state_d    = TO_EXPIRED;
                  tick_cnt_d = {TW{1'b0}};
               end else begin
                  tick_cnt_d = tick_cnt_q + TW'(1);
               end
            end else begin
               tick_cnt_d = tick_cnt_q;
            end
         end
         TO_EXPIRED: begin
            // Only a pop or draining the FIFO leaves EXPIRED
            if (empty_next_i) begin
               state_d    = TO_IDLE;
               tick_cnt_d = {TW{1'b0}};
            end else if (pop_i) begin
               state_d    = TO_COUNT;
               tick_cnt_d = {TW{1'b0}};
            end else begin
               state_d    = TO_EXPIRED;
            end
         end
         default: begin
            state_d    = TO_IDLE;
            tick_cnt_d = {TW{1'b0}};
         end
      endcase
   end

   // State and tick counter registers
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q    <= TO_IDLE;
         tick_cnt_q <= {TW{1'b0}};
      end else begin
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
      end
   end

   assign timeout_o = (state_q == TO_EXPIRED);

endmodule

// File: rtl/rx_buffer_ctrl.sv
// ---------------------------------------------------------------------------
// rx_buffer_ctrl
// UART receive FIFO with show-ahead head output, sticky overrun flag,
// idle-timeout flag and a registered interrupt request.
// Ports:
//   clk, arst              : clock, asynchronous active-high reset
//   brTick8x               : 8x baud tick (timeout timebase)
//   moveDatEn, dat,
//   setPErr, setFErr       : character strobe with data and error bits
//   rdEn                   : CPU pop strobe
//   clrOvr                 : clear overrun
//   rdDat, rdPErr, rdFErr  : head entry
//   rxEmpty, rxFull, count : fill status
//   overrun, rxTimeout     : sticky status flags
//   irq                    : interrupt request (one cycle behind its cause)
// ---------------------------------------------------------------------------
module rx_buffer_ctrl
   import rx_pkg::*;
#(
   parameter int DEPTH         = RX_FIFO_DEPTH,
   parameter int IRQ_LEVEL     = 1,
   parameter int TIMEOUT_TICKS = RX_TIMEOUT_TICKS
) (
   input  logic                     clk,
   input  logic                     arst,
   input  logic                     brTick8x,
   input  logic                     moveDatEn,
   input  logic [7:0]               dat,
   input  logic                     setPErr,
   input  logic                     setFErr,
   input  logic                     rdEn,
   input  logic                     clrOvr,
   output logic [7:0]               rdDat,
   output logic                     rdPErr,
   output logic                     rdFErr,
   output logic                     rxEmpty,
   output logic                     rxFull,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overrun,
   output logic                     rxTimeout,
   output logic                     irq
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
   localparam logic [CW-1:0] IRQ_LVL  = CW'(IRQ_LEVEL);

   rx_entry_t     mem_q [DEPTH];
   rx_entry_t     wr_entry_s;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          overrun_q, overrun_d;
   logic          irq_q, irq_d;
   logic          empty_s, full_s, wr_s, rd_s, drop_s, empty_next_s;
   logic          timeout_s;

   // Write/pop qualification, pointer, level, overrun and irq next-state
   always_comb begin
      empty_s    = (count_q == {CW{1'b0}});
      full_s     = (count_q == FULL_LVL);
      rd_s       = rdEn & ~empty_s;
      // A pop in the same cycle frees the slot, so a full FIFO still accepts
      wr_s       = moveDatEn & (~full_s | rdEn);
      drop_s     = moveDatEn & full_s & ~rdEn;
      wr_entry_s = '{dat: dat, pErr: setPErr, fErr: setFErr};

      wr_ptr_d   = wr_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
      rd_ptr_d   = rd_s ? (rd_ptr_q + AW'(1)) : rd_ptr_q;

      case ({wr_s, rd_s})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      empty_next_s = (count_d == {CW{1'b0}});

      // Setting beats clearing when both happen together
      if (drop_s) begin
         overrun_d = 1'b1;
      end else if (clrOvr) begin
         overrun_d = 1'b0;
      end else begin
         overrun_d = overrun_q;
      end

      irq_d = (count_q >= IRQ_LVL) | overrun_q | timeout_s;
   end

   // Entry storage; cleared on reset so the head reads 0 afterwards
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {$bits(rx_entry_t){1'b0}};
         end
      end else if (wr_s) begin
         mem_q[wr_ptr_q] <= wr_entry_s;
      end
   end

   // Pointers, fill level, overrun and irq registers
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         wr_ptr_q  <= {AW{1'b0}};
         rd_ptr_q  <= {AW{1'b0}};
         count_q   <= {CW{1'b0}};
         overrun_q <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         overrun_q <= overrun_d;
         irq_q     <= irq_d;
      end
   end

   rx_timeout_timer #(
      .TIMEOUT_TICKS (TIMEOUT_TICKS)
   ) u_timer (
      .clk          (clk),
      .arst         (arst),
      .tick_i       (brTick8x),
      .move_i       (moveDatEn),
      .pop_i        (rd_s),
      .empty_next_i (empty_next_s),
      .timeout_o    (timeout_s)
   );

   rx_entry_t head_s;
   assign head_s    = mem_q[rd_ptr_q];
   assign rdDat     = head_s.dat;
   assign rdPErr    = head_s.pErr;
   assign rdFErr    = head_s.fErr;
   assign rxEmpty   = empty_s;
   assign rxFull    = full_s;
   assign count     = count_q;
   assign overrun   = overrun_q;
   assign rxTimeout = timeout_s;
   assign irq       = irq_q;

endmodule
